fp_add_arbiter: RTL and testbench



---
 rtl/fp_add_pkg.sv | 21 ++
 rtl/fp_special_detect.sv | 54 +++++
 rtl/fp_add_arbiter.sv | 166 ++++++++++++++++
 tb/tb_fp_add_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_add_pkg.sv
// Shared types and constants for the shared fp32 adder front-end.
package fp_add_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_HALT
    } state_e;

    localparam int FLG_NAN_A = 0;
    localparam int FLG_NAN_B = 1;
    localparam int FLG_INF_A = 2;
    localparam int FLG_INF_B = 3;
    localparam int FLG_ZERO  = 4;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [7:0]  EXP_MAX = 8'hFF;

endpackage

// File: rtl/fp_special_detect.sv
// Classifies an fp32 operand pair and produces the IEEE result used when
// the adder output cannot be trusted (NaN, infinity, zero/denormal input).
module fp_special_detect
    import fp_add_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [4:0]  flags,
    output logic [31:0] special_sum
);

    logic [7:0] exp_a, exp_b;
    logic       man_a_nz, man_b_nz;
    logic       nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;

    assign exp_a    = a[30:23];
    assign exp_b    = b[30:23];
    assign man_a_nz = |a[22:0];
    assign man_b_nz = |b[22:0];
    assign nan_a    = (exp_a == EXP_MAX) && man_a_nz;
    assign nan_b    = (exp_b == EXP_MAX) && man_b_nz;
    assign inf_a    = (exp_a == EXP_MAX) && !man_a_nz;
    assign inf_b    = (exp_b == EXP_MAX) && !man_b_nz;
    assign zero_a   = (exp_a == 8'h00);
    assign zero_b   = (exp_b == 8'h00);

    always_comb begin
        flags = '0;
        flags[FLG_NAN_A] = nan_a;
        flags[FLG_NAN_B] = nan_b;
        flags[FLG_INF_A] = inf_a;
        flags[FLG_INF_B] = inf_b;
        flags[FLG_ZERO]  = zero_a || zero_b;
    end

    // Priority order matters: NaN and inf-minus-inf dominate, denormals flush to zero.
    always_comb begin
        special_sum = '0;
        if (nan_a || nan_b || (inf_a && inf_b && (a[31] != b[31]))) begin
            special_sum = QNAN;
        end else if (inf_a) begin
            special_sum = a;
        end else if (inf_b) begin
            special_sum = b;
        end else if (zero_a && zero_b) begin
            special_sum = {a[31] & b[31], 31'b0};
        end else if (zero_a) begin
            special_sum = b;
        end else if (zero_b) begin
            special_sum = a;
        end
    end

endmodule

// File: rtl/fp_add_arbiter.sv
// Round-robin front-end sharing one multi-cycle fp32 adder among N requesters,
// with special-value substitution and a sticky watchdog halt.
module fp_add_arbiter
    import fp_add_pkg::*;
#(
    parameter int N       = 4,
    parameter int IDW     = $clog2(N),
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N-1:0]      req_valid,
    output logic [N-1:0]      req_ready,
    input  logic [N*32-1:0]   req_a,
    input  logic [N*32-1:0]   req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [31:0]       rsp_sum,
    output logic              rsp_exc,
    output logic              fault,
    output logic [31:0]       add_a,
    output logic [31:0]       add_b,
    output logic              add_available,
    output logic [4:0]        add_exception_f,
    input  logic [31:0]       add_sum,
    input  logic              add_done
);

    localparam int WDW = $clog2(TIMEOUT);

    state_e           state_q, state_d;
    logic [IDW-1:0]   rr_q, rr_d, id_q, id_d;
    logic [31:0]      a_q, a_d, b_q, b_d, sum_q, sum_d, spec_q, spec_d;
    logic [4:0]       flags_q, flags_d;
    logic             exc_q, exc_d, fault_q, fault_d;
    logic [WDW-1:0]   wd_q, wd_d;

    logic             gnt_found;
    logic [IDW-1:0]   gnt_idx;
    int               scan_idx;
    logic [31:0]      sel_a, sel_b, det_special;
    logic [4:0]       det_flags;

    // First valid requester at or after the rr pointer, wrapping modulo N.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = 0;
        for (int k = 0; k < N; k++) begin
            scan_idx = (int'(rr_q) + k) % N;
            if (!gnt_found && req_valid[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'(scan_idx);
            end
        end
    end

    assign sel_a = req_a[gnt_idx*32 +: 32];
    assign sel_b = req_b[gnt_idx*32 +: 32];

    // Classified on the winning pair so flags land in the same edge as the operands.
    fp_special_detect u_detect (
        .a           (sel_a),
        .b           (sel_b),
        .flags       (det_flags),
        .special_sum (det_special)
    );

    always_comb begin
        state_d       = state_q;
        rr_d          = rr_q;
        id_d          = id_q;
        a_d           = a_q;
        b_d           = b_q;
        flags_d       = flags_q;
        spec_d        = spec_q;
        sum_d         = sum_q;
        exc_d         = exc_q;
        fault_d       = fault_q;
        wd_d          = wd_q;
        req_ready     = '0;
        add_available = 1'b0;
        rsp_valid     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    req_ready[gnt_idx] = 1'b1;
                    a_d     = sel_a;
                    b_d     = sel_b;
                    id_d    = gnt_idx;
                    flags_d = det_flags;
                    spec_d  = det_special;
                    rr_d    = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                add_available = 1'b1;
                wd_d          = '0;
                state_d       = S_WAIT;
            end
            S_WAIT: begin
                // A done landing on the final watchdog cycle still wins.
                if (add_done) begin
                    sum_d   = (flags_q != '0) ? spec_q : add_sum;
                    exc_d   = (flags_q != '0);
                    state_d = S_RESP;
                end else if (wd_q == WDW'(TIMEOUT - 1)) begin
                    sum_d   = QNAN;
                    exc_d   = 1'b1;
                    fault_d = 1'b1;
                    state_d = S_RESP;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = fault_q ? S_HALT : S_IDLE;
                end
            end
            S_HALT: begin
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            flags_q <= '0;
            spec_q  <= '0;
            sum_q   <= '0;
            exc_q   <= 1'b0;
            fault_q <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            flags_q <= flags_d;
            spec_q  <= spec_d;
            sum_q   <= sum_d;
            exc_q   <= exc_d;
            fault_q <= fault_d;
            wd_q    <= wd_d;
        end
    end

    assign rsp_id          = id_q;
    assign rsp_sum         = sum_q;
    assign rsp_exc         = exc_q;
    assign fault           = fault_q;
    assign add_a           = a_q;
    assign add_b           = b_q;
    assign add_exception_f = flags_q;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter with a behavioural multi-cycle adder.
module tb_fp_add_arbiter;

    localparam int N       = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*32-1:0]   req_a;
    logic [N*32-1:0]   req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [31:0]       rsp_sum;
    logic              rsp_exc;
    logic              fault;
    logic [31:0]       add_a;
    logic [31:0]       add_b;
    logic              add_available;
    logic [4:0]        add_exception_f;
    logic [31:0]       add_sum;
    logic              add_done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fp_add_arbiter #(.N(N), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_a           (req_a),
        .req_b           (req_b),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_id          (rsp_id),
        .rsp_sum         (rsp_sum),
        .rsp_exc         (rsp_exc),
        .fault           (fault),
        .add_a           (add_a),
        .add_b           (add_b),
        .add_available   (add_available),
        .add_exception_f (add_exception_f),
        .add_sum         (add_sum),
        .add_done        (add_done)
    );

    // Adder model: equal operands double (exponent + 1), otherwise XOR as a marker.
    bit          hang;
    int          lat;
    int          m_cnt;
    bit          m_busy;
    logic [31:0] m_a, m_b;

    function automatic logic [31:0] model_sum(input logic [31:0] a, input logic [31:0] b);
        return (a == b) ? a + 32'h0080_0000 : a ^ b;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            add_done <= 1'b0;
            add_sum  <= '0;
            m_busy   <= 1'b0;
            m_cnt    <= 0;
            m_a      <= '0;
            m_b      <= '0;
        end else begin
            add_done <= 1'b0;
            if (add_available && !hang) begin
                m_busy <= 1'b1;
                m_cnt  <= lat;
                m_a    <= add_a;
                m_b    <= add_b;
            end else if (m_busy) begin
                if (m_cnt <= 1) begin
                    add_done <= 1'b1;
                    add_sum  <= model_sum(m_a, m_b);
                    m_busy   <= 1'b0;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        reset     = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        hang      = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Drives one request on a single port and collects what the DUT shows.
    task automatic run_one(input int port, input logic [31:0] a, input logic [31:0] b,
                           output logic [4:0] fl, output logic [31:0] oa, output logic [31:0] ob,
                           output int avail_n, output logic [IDW-1:0] id,
                           output logic [31:0] sum, output logic exc, output bit ok);
        int t;
        ok = 0; avail_n = 0; fl = '0; oa = '0; ob = '0; id = '0; sum = '0; exc = 1'b0;
        @(posedge clk); #1;
        req_valid = N'(1) << port;
        req_a[port*32 +: 32] = a;
        req_b[port*32 +: 32] = b;
        rsp_ready = 1'b1;
        t = 0;
        @(negedge clk);
        while (!req_ready[port] && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready[port]) begin
            req_valid = '0;
            return;
        end
        @(posedge clk); #1;
        req_valid = '0;
        t = 0;
        @(negedge clk);
        while (!rsp_valid && t < 200) begin
            if (add_available) begin
                avail_n++;
                fl = add_exception_f;
                oa = add_a;
                ob = add_b;
            end
            @(negedge clk);
            t++;
        end
        if (!rsp_valid) return;
        id  = rsp_id;
        sum = rsp_sum;
        exc = rsp_exc;
        ok  = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if ({req_ready, rsp_valid, rsp_id, rsp_sum, rsp_exc, fault, add_a, add_b,
             add_available, add_exception_f} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got rdy=%b vld=%b id=%0d sum=%h exc=%b fault=%b a=%h b=%h av=%b exc_f=%b want all 0",
                     req_ready, rsp_valid, rsp_id, rsp_sum, rsp_exc, fault, add_a, add_b,
                     add_available, add_exception_f);
        end
    endtask

    task automatic test_single();
        logic [4:0] fl; logic [31:0] oa, ob, sum; int av; logic [IDW-1:0] id; logic exc; bit ok;
        run_one(2, 32'h3F80_0000, 32'h3F80_0000, fl, oa, ob, av, id, sum, exc, ok);
        n_tests++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL single_handshake got timeout want response"); end
        n_tests++;
        if (av !== 1) begin n_fail++; $display("FAIL single_avail_cycles got %0d want 1", av); end
        n_tests++;
        if (oa !== 32'h3F80_0000 || ob !== 32'h3F80_0000) begin
            n_fail++; $display("FAIL single_operands got %h/%h want 3f800000/3f800000", oa, ob);
        end
        n_tests++;
        if (fl !== 5'b00000) begin n_fail++; $display("FAIL single_flags got %b want 00000", fl); end
        n_tests++;
        if (id !== 2'd2) begin n_fail++; $display("FAIL single_id got %0d want 2", id); end
        n_tests++;
        if (sum !== 32'h4000_0000) begin n_fail++; $display("FAIL single_sum got %h want 40000000", sum); end
        n_tests++;
        if (exc !== 1'b0) begin n_fail++; $display("FAIL single_exc got %b want 0", exc); end
    endtask

    task automatic test_round_robin();
        int exp_ord[4] = '{0, 1, 3, 0};
        int t;
        apply_reset();
        @(posedge clk); #1;
        for (int p = 0; p < N; p++) begin
            req_a[p*32 +: 32] = 32'h3F80_0000 + 32'(p);
            req_b[p*32 +: 32] = 32'h3F80_0000 + 32'(p);
        end
        req_valid = 4'b1011;
        rsp_ready = 1'b1;
        for (int g = 0; g < 4; g++) begin
            t = 0;
            @(negedge clk);
            while (req_ready == '0 && t < 100) begin
                @(negedge clk);
                t++;
            end
            n_tests++;
            if ($countones(req_ready) != 1) begin
                n_fail++; $display("FAIL rr_onehot grant %0d got %b want one bit", g, req_ready);
            end
            n_tests++;
            if (req_ready !== (N'(1) << exp_ord[g])) begin
                n_fail++; $display("FAIL rr_order grant %0d got %b want port %0d", g, req_ready, exp_ord[g]);
            end
            @(posedge clk);
        end
        #1;
        req_valid = '0;
        repeat (20) @(posedge clk);
    endtask

    task automatic test_specials();
        logic [4:0] fl; logic [31:0] oa, ob, sum; int av; logic [IDW-1:0] id; logic exc; bit ok;
        run_one(1, 32'h7F80_0000, 32'hFF80_0000, fl, oa, ob, av, id, sum, exc, ok);
        n_tests++;
        if (fl !== 5'b01100) begin n_fail++; $display("FAIL inf_flags got %b want 01100", fl); end
        n_tests++;
        if (sum !== 32'h7FC0_0000) begin n_fail++; $display("FAIL inf_sum got %h want 7fc00000", sum); end
        n_tests++;
        if (exc !== 1'b1 || id !== 2'd1) begin n_fail++; $display("FAIL inf_exc_id got %b/%0d want 1/1", exc, id); end

        run_one(1, 32'h0000_0000, 32'h4049_0FDB, fl, oa, ob, av, id, sum, exc, ok);
        n_tests++;
        if (fl !== 5'b10000) begin n_fail++; $display("FAIL zero_flags got %b want 10000", fl); end
        n_tests++;
        if (sum !== 32'h4049_0FDB) begin n_fail++; $display("FAIL zero_sum got %h want 40490fdb", sum); end
        n_tests++;
        if (exc !== 1'b1) begin n_fail++; $display("FAIL zero_exc got %b want 1", exc); end

        run_one(1, 32'h8000_0000, 32'h8000_0000, fl, oa, ob, av, id, sum, exc, ok);
        n_tests++;
        if (sum !== 32'h8000_0000) begin n_fail++; $display("FAIL negzero_sum got %h want 80000000", sum); end

        run_one(3, 32'h7FC1_2345, 32'h3F80_0000, fl, oa, ob, av, id, sum, exc, ok);
        n_tests++;
        if (fl !== 5'b00001 || sum !== 32'h7FC0_0000) begin
            n_fail++; $display("FAIL nan_a got flags %b sum %h want 00001 7fc00000", fl, sum);
        end
    endtask

    task automatic test_backpressure();
        int t;
        @(posedge clk); #1;
        req_a[31:0] = 32'h4000_0000;
        req_b[31:0] = 32'h4000_0000;
        req_valid   = 4'b0001;
        rsp_ready   = 1'b0;
        t = 0;
        @(negedge clk);
        while (!req_ready[0] && t < 50) begin @(negedge clk); t++; end
        @(posedge clk); #1;
        req_valid = 4'b1000;
        t = 0;
        @(negedge clk);
        while (!rsp_valid && t < 50) begin @(negedge clk); t++; end
        for (int c = 0; c < 10; c++) begin
            n_tests++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 32'h4080_0000 || req_ready !== '0) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d got vld=%b id=%0d sum=%h rdy=%b want 1/0/40800000/0000",
                         c, rsp_valid, rsp_id, rsp_sum, req_ready);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        t = 0;
        @(negedge clk);
        while (req_ready == '0 && t < 20) begin @(negedge clk); t++; end
        n_tests++;
        if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL bp_next_grant got %b want 1000", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        repeat (20) @(posedge clk);
    endtask

    task automatic test_timeout();
        int t;
        bit bad;
        @(posedge clk); #1;
        hang = 1'b1;
        req_a[64 +: 32] = 32'h3F80_0000;
        req_b[64 +: 32] = 32'h4000_0000;
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        t = 0;
        @(negedge clk);
        while (!req_ready[2] && t < 50) begin @(negedge clk); t++; end
        @(posedge clk); #1;
        req_valid = '0;
        t = 0;
        @(negedge clk);
        while (!add_available && t < 10) begin @(negedge clk); t++; end
        n_tests++;
        if (fault !== 1'b0) begin n_fail++; $display("FAIL wd_early_fault got %b want 0", fault); end
        t = 0;
        while (!rsp_valid && t < 200) begin @(negedge clk); t++; end
        n_tests++;
        if (t < 62 || t > 65) begin n_fail++; $display("FAIL wd_latency got %0d cycles want 62..65", t); end
        n_tests++;
        if (rsp_sum !== 32'h7FC0_0000 || rsp_exc !== 1'b1) begin
            n_fail++; $display("FAIL wd_result got %h/%b want 7fc00000/1", rsp_sum, rsp_exc);
        end
        n_tests++;
        if (fault !== 1'b1 || rsp_id !== 2'd2) begin
            n_fail++; $display("FAIL wd_fault_id got %b/%0d want 1/2", fault, rsp_id);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (req_ready !== '0 || add_available !== 1'b0 || rsp_valid !== 1'b0 || fault !== 1'b1) bad = 1;
        end
        n_tests++;
        if (bad) begin n_fail++; $display("FAIL halt_no_grant got activity after fault want none"); end
        req_valid = '0;
    endtask

    task automatic test_reset_midwait();
        int t;
        apply_reset();
        n_tests++;
        if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_clears_fault got %b want 0", fault); end
        hang = 1'b1;
        @(posedge clk); #1;
        req_a[32 +: 32] = 32'h4040_0000;
        req_b[32 +: 32] = 32'h4040_0000;
        req_valid = 4'b0010;
        t = 0;
        @(negedge clk);
        while (!add_available && t < 20) begin @(negedge clk); t++; end
        req_valid = '0;
        repeat (5) @(negedge clk);
        n_tests++;
        if (add_a !== 32'h4040_0000) begin n_fail++; $display("FAIL midwait_operand got %h want 40400000", add_a); end
        reset = 1'b1;
        #1;
        n_tests++;
        if ({req_ready, rsp_valid, rsp_id, rsp_sum, rsp_exc, fault, add_a, add_b,
             add_available, add_exception_f} !== '0) begin
            n_fail++;
            $display("FAIL midwait_reset got id=%0d sum=%h fault=%b a=%h b=%h exc_f=%b want all 0",
                     rsp_id, rsp_sum, fault, add_a, add_b, add_exception_f);
        end
        @(negedge clk);
        reset = 1'b0;
        hang  = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        hang      = 1'b0;
        lat       = 2;
        test_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        test_single();
        test_round_robin();
        test_specials();
        test_backpressure();
        test_timeout();
        test_reset_midwait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
